// File: rtl/press_classifier_pkg.sv
// rtl/press_classifier_pkg.sv - shared encodings for the press classifier
// Purpose: state encoding and event codes used by press_classifier and its bench.
// Ports: none (package).
package press_classifier_pkg;

   localparam logic [2:0] ENC_ARM    = 3'd0;
   localparam logic [2:0] ENC_IDLE   = 3'd1;
   localparam logic [2:0] ENC_PRESS1 = 3'd2;
   localparam logic [2:0] ENC_WAIT2  = 3'd3;
   localparam logic [2:0] ENC_DRAIN  = 3'd4;

   typedef enum logic [2:0] {
      ST_ARM    = ENC_ARM,
      ST_IDLE   = ENC_IDLE,
      ST_PRESS1 = ENC_PRESS1,
      ST_WAIT2  = ENC_WAIT2,
      ST_DRAIN  = ENC_DRAIN
   } state_e;

   localparam logic [1:0] EVT_NONE   = 2'b00;
   localparam logic [1:0] EVT_SHORT  = 2'b01;
   localparam logic [1:0] EVT_LONG   = 2'b10;
   localparam logic [1:0] EVT_DOUBLE = 2'b11;

endpackage

// File: rtl/press_classifier_if.sv
// rtl/press_classifier_if.sv - button-level input and classification outputs
// Purpose: bundles the debounced level and the event outputs of press_classifier.
// Signals: db_level (to classifier), short_tick/long_tick/double_tick (one-cycle
//          events), last_evt (most recent event code), busy (press being tracked).
// Modports: master drives db_level and observes outputs; slave is the classifier.
interface press_classifier_if;
   logic       db_level;
   logic       short_tick;
   logic       long_tick;
   logic       double_tick;
   logic [1:0] last_evt;
   logic       busy;

   modport master (
      output db_level,
      input  short_tick, long_tick, double_tick, last_evt, busy
   );

   modport slave (
      input  db_level,
      output short_tick, long_tick, double_tick, last_evt, busy
   );
endinterface

// File: rtl/press_timer.sv
// rtl/press_timer.sv - loadable up-counter with limit compare
// Purpose: counts press / gap samples for the classifier FSM.
// Ports: clk, reset_n (async active-low), load1 (set count to 1), inc (count+1),
//        limit (runtime terminal value), hit (the next increment reaches limit).
module press_timer #(
   parameter int CNT_W = 26
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load1,
   input  logic             inc,
   input  logic [CNT_W-1:0] limit,
   output logic             hit
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load1) begin
         count_d = ONE;
      end else if (inc) begin
         count_d = count_q + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Looks one sample ahead so the FSM can register the tick on the same edge
   // at which the count reaches the limit.
   assign hit = (count_q == limit - ONE);

endmodule

// File: rtl/press_classifier.sv
// rtl/press_classifier.sv - classifies debounced presses as short, long or double
// Purpose: turns the debounced button level into one-cycle event ticks plus a
//          held last-event code.
// Ports: clk, reset_n (async active-low), bus (press_classifier_if.slave):
//        db_level in; short_tick, long_tick, double_tick, last_evt, busy out.
// Build option: PRESS_CLASSIFIER_DOUBLE_EN enables double-press detection
//               (WAIT2 state); when undefined a short press reports on release.
module press_classifier
   import press_classifier_pkg::*;
#(
   parameter int LONG_CYC = 50_000_000,
   parameter int DBL_CYC  = 25_000_000,
   parameter int CNT_W    = 26
) (
   input  logic               clk,
   input  logic               reset_n,
   press_classifier_if.slave  bus
);

   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC);
   localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CYC);

   state_e     state_q, state_d;
   logic       short_q, short_d;
   logic       long_q, long_d;
   logic       dbl_q, dbl_d;
   logic [1:0] last_q, last_d;
   logic       busy_q, busy_d;

   logic             load1;
   logic             inc;
   logic             hit;
   logic [CNT_W-1:0] limit;

   press_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .load1   (load1),
      .inc     (inc),
      .limit   (limit),
      .hit     (hit)
   );

   always_comb begin
      state_d = state_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      dbl_d   = 1'b0;
      last_d  = last_q;
      load1   = 1'b0;
      inc     = 1'b0;
      limit   = (state_q == ST_WAIT2) ? DBL_LIM : LONG_LIM;

      case (state_q)
         // A level already high when reset releases must be seen low once
         // before it can start a press.
         ST_ARM: begin
            if (!bus.db_level) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.db_level) begin
               state_d = ST_PRESS1;
               load1   = 1'b1;
            end
         end
         ST_PRESS1: begin
            if (bus.db_level) begin
               inc = 1'b1;
               if (hit) begin
                  long_d  = 1'b1;
                  last_d  = EVT_LONG;
                  state_d = ST_DRAIN;
               end
            end else begin
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
               // The release sample is the first gap sample; a one-sample
               // window is therefore already complete here.
               if (DBL_CYC == 1) begin
                  short_d = 1'b1;
                  last_d  = EVT_SHORT;
                  state_d = ST_IDLE;
               end else begin
                  load1   = 1'b1;
                  state_d = ST_WAIT2;
               end
`else
               short_d = 1'b1;
               last_d  = EVT_SHORT;
               state_d = ST_IDLE;
`endif
            end
         end
         ST_WAIT2: begin
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
            // A re-press wins over the window closing on the same edge.
            if (bus.db_level) begin
               dbl_d   = 1'b1;
               last_d  = EVT_DOUBLE;
               state_d = ST_DRAIN;
            end else begin
               inc = 1'b1;
               if (hit) begin
                  short_d = 1'b1;
                  last_d  = EVT_SHORT;
                  state_d = ST_IDLE;
               end
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DRAIN: begin
            if (!bus.db_level) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_ARM;
         end
      endcase

      busy_d = !((state_d == ST_IDLE) || (state_d == ST_ARM));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_ARM;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         dbl_q   <= 1'b0;
         last_q  <= EVT_NONE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         short_q <= short_d;
         long_q  <= long_d;
         dbl_q   <= dbl_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.short_tick  = short_q;
   assign bus.long_tick   = long_q;
   assign bus.double_tick = dbl_q;
   assign bus.last_evt    = last_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_press_classifier.sv
// tb/tb_press_classifier.sv - scoreboard bench for press_classifier
module tb_press_classifier;
   import press_classifier_pkg::*;

   localparam int LONG_CYC = 8;
   localparam int DBL_CYC  = 4;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
   localparam int SHORT_LAT = DBL_CYC;
`else
   localparam int SHORT_LAT = 1;
`endif

   typedef struct {
      logic [1:0] evt;
      int         edge_n;
   } exp_t;

   logic clk;
   logic reset_n;
   int   edge_cnt;
   int   checks;
   int   failures;
   exp_t sb[$];

   press_classifier_if bus();

   press_classifier #(
      .LONG_CYC (LONG_CYC),
      .DBL_CYC  (DBL_CYC),
      .CNT_W    (4)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Monitor: every tick is popped from the scoreboard and checked for type,
   // edge and last_evt; last_evt must not move without a tick.
   int         n_ticks;
   logic [1:0] got_evt;
   logic [1:0] prev_last;
   bit         prev_valid;
   exp_t       e;

   initial prev_valid = 1'b0;

   always @(negedge clk) begin
      n_ticks = int'(bus.short_tick) + int'(bus.long_tick) + int'(bus.double_tick);
      checks++;
      if (n_ticks > 1) begin
         failures++;
         $display("FAIL one_tick edge=%0d got=%0d ticks required<=1", edge_cnt, n_ticks);
      end
      if (n_ticks == 1) begin
         got_evt = bus.short_tick ? EVT_SHORT : (bus.long_tick ? EVT_LONG : EVT_DOUBLE);
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_tick edge=%0d got_evt=%0d required none", edge_cnt, got_evt);
         end else begin
            e = sb.pop_front();
            if (got_evt !== e.evt || edge_cnt !== e.edge_n) begin
               failures++;
               $display("FAIL tick got evt=%0d edge=%0d required evt=%0d edge=%0d",
                        got_evt, edge_cnt, e.evt, e.edge_n);
            end
            checks++;
            if (bus.last_evt !== e.evt) begin
               failures++;
               $display("FAIL last_evt_on_tick got=%0d required=%0d", bus.last_evt, e.evt);
            end
         end
      end else if (reset_n && prev_valid) begin
         checks++;
         if (bus.last_evt !== prev_last) begin
            failures++;
            $display("FAIL last_evt_hold edge=%0d got=%0d required=%0d", edge_cnt, bus.last_evt, prev_last);
         end
      end
      prev_last  = bus.last_evt;
      prev_valid = reset_n;
   end

   task automatic check_idle_outputs(input string name);
      checks++;
      if ({bus.short_tick, bus.long_tick, bus.double_tick, bus.busy} !== 4'b0) begin
         failures++;
         $display("FAIL %s ticks_busy got=%b required=0000", name,
                  {bus.short_tick, bus.long_tick, bus.double_tick, bus.busy});
      end
   endtask

   task automatic check_drained(input string name, input logic [1:0] exp_last);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s missing_ticks got=%0d pending required=0", name, sb.size());
         sb.delete();
      end
      checks++;
      if (bus.last_evt !== exp_last) begin
         failures++;
         $display("FAIL %s last_evt got=%0d required=%0d", name, bus.last_evt, exp_last);
      end
   endtask

   // High 3, then low until the short tick; busy must fall on the tick edge.
   task automatic test_short();
      int a, se;
      bit exp_busy;
      a  = edge_cnt + 1;
      se = a + 3 + SHORT_LAT - 1;
      sb.push_back('{EVT_SHORT, se});
      bus.db_level = 1'b1;
      repeat (3) @(negedge clk);
      bus.db_level = 1'b0;
      for (int i = 0; i < SHORT_LAT + 3; i++) begin
         @(negedge clk);
         exp_busy = (edge_cnt < se);
         checks++;
         if (bus.busy !== exp_busy) begin
            failures++;
            $display("FAIL short_busy edge=%0d got=%b required=%b", edge_cnt, bus.busy, exp_busy);
         end
      end
      check_drained("short", EVT_SHORT);
   endtask

   task automatic test_reset();
      reset_n      = 1'b0;
      bus.db_level = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      checks++;
      if (bus.last_evt !== EVT_NONE) begin
         failures++;
         $display("FAIL reset_last_evt got=%0d required=0", bus.last_evt);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_idle_outputs("held_through_reset");
      end
      bus.db_level = 1'b0;
      repeat (2) @(negedge clk);
      test_short();
   endtask

   task automatic test_long();
      int a;
      a = edge_cnt + 1;
      sb.push_back('{EVT_LONG, a + LONG_CYC - 1});
      bus.db_level = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL long_busy_held edge=%0d got=%b required=1", edge_cnt, bus.busy);
         end
      end
      bus.db_level = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL long_busy_release edge=%0d got=%b required=0", edge_cnt, bus.busy);
      end
      repeat (3) @(negedge clk);
      check_drained("long", EVT_LONG);
   endtask

   // High 3, low 2, high 5, low.
   task automatic test_double();
      int a;
      logic [1:0] exp_last;
      a = edge_cnt + 1;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
      sb.push_back('{EVT_DOUBLE, a + 5});
      exp_last = EVT_DOUBLE;
`else
      sb.push_back('{EVT_SHORT, a + 3});
      sb.push_back('{EVT_SHORT, a + 10});
      exp_last = EVT_SHORT;
`endif
      bus.db_level = 1'b1;
      repeat (3) @(negedge clk);
      bus.db_level = 1'b0;
      repeat (2) @(negedge clk);
      bus.db_level = 1'b1;
      repeat (5) @(negedge clk);
      bus.db_level = 1'b0;
      repeat (DBL_CYC + 3) @(negedge clk);
      check_drained("double", exp_last);
   endtask

   // Re-press on the sample that would otherwise close the window.
   task automatic test_double_boundary();
      int a;
      logic [1:0] exp_last;
      a = edge_cnt + 1;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
      sb.push_back('{EVT_DOUBLE, a + 3 + DBL_CYC - 1});
      exp_last = EVT_DOUBLE;
`else
      sb.push_back('{EVT_SHORT, a + 3});
      sb.push_back('{EVT_SHORT, a + 3 + DBL_CYC + 1});
      exp_last = EVT_SHORT;
`endif
      bus.db_level = 1'b1;
      repeat (3) @(negedge clk);
      bus.db_level = 1'b0;
      repeat (DBL_CYC - 1) @(negedge clk);
      bus.db_level = 1'b1;
      repeat (2) @(negedge clk);
      bus.db_level = 1'b0;
      repeat (DBL_CYC + 3) @(negedge clk);
      check_drained("double_boundary", exp_last);
   endtask

   task automatic test_reset_mid();
      bus.db_level = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_busy_before_reset got=%b required=1", bus.busy);
      end
      reset_n = 1'b0;
      #1;
      check_idle_outputs("mid_reset");
      checks++;
      if (bus.last_evt !== EVT_NONE) begin
         failures++;
         $display("FAIL mid_reset_last_evt got=%0d required=0", bus.last_evt);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_idle_outputs("after_mid_reset");
      end
      bus.db_level = 1'b0;
      repeat (2) @(negedge clk);
      test_short();
   endtask

   // High 3, low 1, high 3, low.
   task automatic test_back_to_back();
      int a;
      logic [1:0] exp_last;
      a = edge_cnt + 1;
`ifdef PRESS_CLASSIFIER_DOUBLE_EN
      sb.push_back('{EVT_DOUBLE, a + 4});
      exp_last = EVT_DOUBLE;
`else
      sb.push_back('{EVT_SHORT, a + 3});
      sb.push_back('{EVT_SHORT, a + 7});
      exp_last = EVT_SHORT;
`endif
      bus.db_level = 1'b1;
      repeat (3) @(negedge clk);
      bus.db_level = 1'b0;
      @(negedge clk);
      bus.db_level = 1'b1;
      repeat (3) @(negedge clk);
      bus.db_level = 1'b0;
      repeat (DBL_CYC + 3) @(negedge clk);
      check_drained("back_to_back", exp_last);
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset_n      = 1'b0;
      bus.db_level = 1'b1;
      test_reset();
      test_long();
      test_short();
      test_double();
      test_double_boundary();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/press_classifier.md
# press_classifier

Consumes the debounced button level from the input debouncer and classifies each press as short, long or double. Each classification is reported as a one-cycle tick, and the most recent event is held in a register. Sits between the debounce stage and the application control FSMs, so downstream logic never counts cycles itself.

## Interface
- `LONG_CYC`, default 50_000_000: consecutive high samples that make a long press; must be ≥2.
- `DBL_CYC`, default 25_000_000: low samples allowed between presses for a double; must be ≥1.
- `CNT_W`, default 26: counter width; must satisfy both `LONG_CYC` and `DBL_CYC` < 2^`CNT_W`.
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `db_level` in 1: debounced button level, synchronous to `clk`.
- `short_tick` out 1: one-cycle pulse for a short press.
- `long_tick` out 1: one-cycle pulse for a long press.
- `double_tick` out 1: one-cycle pulse for a double press.
- `last_evt` out 2: last event; 00 none, 01 short, 10 long, 11 double.
- `busy` out 1: high in every state except IDLE and ARM.

## Operation
- States: ARM, IDLE, PRESS1, WAIT2, DRAIN.
- ARM: entered on reset. `db_level` low → IDLE. A level held high through reset never counts as a press.
- IDLE: `db_level` high → PRESS1, counter=1.
- PRESS1, `db_level` high: counter++. When the counter reaches `LONG_CYC`, pulse `long_tick`, set `last_evt`=10, go to DRAIN.
- PRESS1, `db_level` low: go to WAIT2 with counter=1. If the macro is absent, instead pulse `short_tick`, set `last_evt`=01, go to IDLE.
- WAIT2, `db_level` high: pulse `double_tick`, set `last_evt`=11, go to DRAIN.
- WAIT2, `db_level` low: counter++. When the counter reaches `DBL_CYC`, pulse `short_tick`, set `last_evt`=01, go to IDLE.
- DRAIN: `db_level` low → IDLE. No further events are produced while the button stays held.
- At most one tick is asserted in any cycle.
- The counter never wraps, because every path leaves the counting state before the counter can exceed its limit.
- Reset values: all ticks 0, `last_evt`=00, `busy`=0, counter 0, state ARM.
- Reset asserted mid-operation clears everything immediately. A press in progress is discarded silently.
- `last_evt` changes only on the edge that fires a tick.

## Timing
- All outputs are registered. A tick is high for exactly the one cycle following the edge that made the decision.
- Long press: `long_tick` is high in the cycle after the edge on which `db_level` has been sampled high on `LONG_CYC` consecutive edges.
- Short press, with macro: `short_tick` follows the `DBL_CYC`-th consecutive low sample after release.
- Short press, without macro: `short_tick` follows the first low sample after release.
- Double press: `double_tick` follows the first high sample within the window.
- Boundary: a re-press arriving exactly on the edge where the counter would reach `DBL_CYC` is a double; the high sample takes priority.
- `busy` is registered with the state: it rises on the edge entering PRESS1 and falls on the edge entering IDLE.

## Configuration
- `PRESS_CLASSIFIER_DOUBLE_EN` defined: WAIT2 exists, `double_tick` can fire, and short presses incur `DBL_CYC` cycles of latency.
- Macro undefined: WAIT2 is removed and `double_tick` is tied to 0. A short press reports immediately on release, and `last_evt` never takes the value 11.

## Structure
- Package `press_classifier_pkg` holds:
  - the state encoding (3-bit localparams for the five states);
  - the event codes `EVT_NONE`, `EVT_SHORT`, `EVT_LONG`, `EVT_DOUBLE`.
- Sub-module `press_timer`: a loadable up-counter of width `CNT_W`, with `load1`, `inc` and a `hit` compare against a runtime limit input. The FSM drives it with `LONG_CYC` or `DBL_CYC` as the limit.

## Test plan
All scenarios use `LONG_CYC`=8, `DBL_CYC`=4, macro defined unless stated.
1. Release reset with `db_level`=1, hold 20 cycles → no ticks, `busy`=0. Drop low, then press 3 cycles → normal classification resumes.
2. High 3 cycles, then low → `short_tick` on the cycle after the 4th low sample; `last_evt`=01; `busy` falls on the same edge.
3. High 30 cycles → `long_tick` once, after the 8th high sample; no other ticks; `busy` stays high until the first low sample.
4. High 3, low 2, high 5, low → exactly one `double_tick`, after the re-press sample; no `short_tick`; `last_evt`=11.
5. High 5, then assert `reset_n`=0 for 2 cycles while the button stays high → outputs 0 immediately; no tick fires after reset release until a low-then-high sequence.
6. Macro undefined: high 3, low 1, high 3, low → two `short_tick` pulses, each on the cycle after a release; `double_tick` never asserts.
